// File: rtl/nand3_vector_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nand3_vector_tester                                                        |
// | Gray-code stimulus/response checker for a 3-input NAND gate under test.    |
// | Optional: NAND3_TESTER_STOP_ON_FAIL_EN ends the run at the first mismatch. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nand3_vector_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_w,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] vec_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_cnt_load = 8'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [2:0] r_vec, w_vec_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_pass, w_pass_nxt;

  logic       w_expect;
  logic       w_mismatch;
  logic [2:0] w_idx_inc;
  logic [3:0] w_err_inc;

  assign w_expect   = ~(r_vec[2] & r_vec[1] & r_vec[0]);
  // Case inequality so an X or Z on the gate output is scored as a failure.
  assign w_mismatch = (dut_w !== w_expect);
  assign w_idx_inc  = r_idx + 3'd1;
  assign w_err_inc  = r_err + {3'd0, w_mismatch};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_busy_nxt  = r_busy;
    w_pass_nxt  = r_pass;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = c_cnt_load;
          w_idx_nxt   = 3'd0;
          w_vec_nxt   = 3'd0;
          w_err_nxt   = 4'd0;
          w_busy_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
        end else if (r_state == ST_DONE) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      ST_SAMPLE: begin
        w_err_nxt = w_err_inc;
`ifdef NAND3_TESTER_STOP_ON_FAIL_EN
        if (w_mismatch || (r_idx == 3'd7)) begin
`else
        if (r_idx == 3'd7) begin
`endif
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = (w_err_inc == 4'd0);
        end else begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = w_idx_inc;
          // Binary-to-Gray so consecutive vectors differ in a single input.
          w_vec_nxt   = w_idx_inc ^ (w_idx_inc >> 1);
          w_cnt_nxt   = c_cnt_load;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_vec   <= 3'd0;
      r_err   <= 4'd0;
      r_busy  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign dut_a     = r_vec[2];
  assign dut_b     = r_vec[1];
  assign dut_c     = r_vec[0];
  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_nand3_vector_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nand3_vector_tester                                                     |
// | Directed bench: ideal, stuck, AND3, delayed gate models and mid-run reset. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nand3_vector_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dut_a, dut_b, dut_c, dut_w;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] vec_idx;

  logic [2:0] mode = 3'd0;
  logic [4:0] r_dly = 5'b11111;

  int tests = 0;
  int fails = 0;
  int cyc;

`ifdef NAND3_TESTER_STOP_ON_FAIL_EN
  localparam int c_stuck_cyc = 31, c_stuck_err = 1, c_stuck_idx = 5, c_stuck_abc = 7;
  localparam int c_and_cyc   = 6,  c_and_err   = 1, c_and_idx   = 0;
  localparam int c_d5_cyc    = 31, c_d5_err    = 1, c_d5_idx    = 5;
`else
  localparam int c_stuck_cyc = 41, c_stuck_err = 1, c_stuck_idx = 7, c_stuck_abc = 4;
  localparam int c_and_cyc   = 41, c_and_err   = 8, c_and_idx   = 7;
  localparam int c_d5_cyc    = 41, c_d5_err    = 2, c_d5_idx    = 7;
`endif

  nand3_vector_tester #(.SETTLE_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_c     (dut_c),
    .dut_w     (dut_w),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_idx   (vec_idx)
  );

  always #5 clk = ~clk;

  // Gate models: 0 ideal, 1 stuck-at-1, 2 AND3, 3 four-cycle delay, 4 five-cycle delay
  always @(posedge clk) r_dly <= {r_dly[3:0], ~(dut_a & dut_b & dut_c)};

  always_comb begin
    dut_w = ~(dut_a & dut_b & dut_c);
    case (mode)
      3'd1:    dut_w = 1'b1;
      3'd2:    dut_w = dut_a & dut_b & dut_c;
      3'd3:    dut_w = r_dly[3];
      3'd4:    dut_w = r_dly[4];
      default: dut_w = ~(dut_a & dut_b & dut_c);
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run and returns the cycle number (cycle 1 follows E0) in which done is seen.
  task automatic run(input int pulse_at, output int done_cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", {15'd0, busy}, 16'd1);
    check("start_abc", {13'd0, dut_a, dut_b, dut_c}, 16'd0);
    check("start_idx_err_pass", {8'd0, vec_idx, err_count, pass}, 16'd0);
    done_cyc = 1;
    while (done !== 1'b1 && done_cyc < 300) begin
      @(posedge clk); #1;
      done_cyc++;
      start = (done_cyc == pulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {dut_a, dut_b, dut_c, busy, done, pass, err_count, vec_idx, 3'd0}, 16'd0);
    rst_n = 1'b1;

    // Ideal NAND, with a stray start mid-run that must be ignored
    mode = 3'd0;
    run(10, cyc);
    check("ideal_done_cycle", 16'(cyc), 16'd41);
    check("ideal_err", {12'd0, err_count}, 16'd0);
    check("ideal_pass", {15'd0, pass}, 16'd1);
    check("ideal_idx", {13'd0, vec_idx}, 16'd7);
    check("ideal_abc", {13'd0, dut_a, dut_b, dut_c}, 16'd4);
    check("ideal_busy_low", {15'd0, busy}, 16'd0);
    @(posedge clk); #1;
    check("ideal_done_pulse", {15'd0, done}, 16'd0);
    check("ideal_pass_held", {15'd0, pass}, 16'd1);

    // Stuck-at-1 output: only vector 111 fails
    mode = 3'd1;
    run(0, cyc);
    check("stuck_done_cycle", 16'(cyc), 16'(c_stuck_cyc));
    check("stuck_err", {12'd0, err_count}, 16'(c_stuck_err));
    check("stuck_pass", {15'd0, pass}, 16'd0);
    check("stuck_idx", {13'd0, vec_idx}, 16'(c_stuck_idx));
    check("stuck_abc", {13'd0, dut_a, dut_b, dut_c}, 16'(c_stuck_abc));

    // AND3 instead of NAND3: every vector inverted
    mode = 3'd2;
    run(0, cyc);
    check("and3_done_cycle", 16'(cyc), 16'(c_and_cyc));
    check("and3_err", {12'd0, err_count}, 16'(c_and_err));
    check("and3_pass", {15'd0, pass}, 16'd0);
    check("and3_idx", {13'd0, vec_idx}, 16'(c_and_idx));

    // Delay equal to the settle time still passes
    mode = 3'd3;
    run(0, cyc);
    check("d4_done_cycle", 16'(cyc), 16'd41);
    check("d4_err", {12'd0, err_count}, 16'd0);
    check("d4_pass", {15'd0, pass}, 16'd1);

    // One cycle too slow: indices 5 and 6 see the previous vector's result
    mode = 3'd4;
    run(0, cyc);
    check("d5_done_cycle", 16'(cyc), 16'(c_d5_cyc));
    check("d5_err", {12'd0, err_count}, 16'(c_d5_err));
    check("d5_pass", {15'd0, pass}, 16'd0);
    check("d5_idx", {13'd0, vec_idx}, 16'(c_d5_idx));

    // Asynchronous reset at cycle 20 of a failing run
    mode = 3'd2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {dut_a, dut_b, dut_c, busy, done, pass, err_count, vec_idx, 3'd0}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle", {dut_a, dut_b, dut_c, busy, done, pass, err_count, vec_idx, 3'd0}, 16'd0);

    mode = 3'd0;
    run(0, cyc);
    check("rerun_done_cycle", 16'(cyc), 16'd41);
    check("rerun_err", {12'd0, err_count}, 16'd0);
    check("rerun_pass", {15'd0, pass}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nand3_vector_tester.md
# nand3_vector_tester

Clocked stimulus/response engine for the 3-input NAND gate models (switch-level or gate-level) under test in the lab flow. It drives the gate's `a`, `b` and `c` inputs through all 8 input combinations in Gray-code order. After each vector it waits a programmable settle time, samples the gate output and compares it with the ideal NAND result. It then reports the mismatch count and a pass flag. It is the checking end of the NAND_3 interface: the NAND_3 gate produces `w`, and this block generates the inputs and judges `w`.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles between applying a vector and sampling `dut_w`. Legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled run request. Accepted only in IDLE or DONE.
- `dut_a` out 1: NAND input a (vector bit 2).
- `dut_b` out 1: NAND input b (vector bit 1).
- `dut_c` out 1: NAND input c (vector bit 0).
- `dut_w` in 1: NAND output under test.
- `busy` out 1: high from the accepting edge until the DONE state is entered.
- `done` out 1: one-cycle pulse in the DONE state.
- `pass` out 1: 1 when the last completed run had `err_count==0`. Held until the next start.
- `err_count` out 4: mismatches in the current or last run (0..8).
- `vec_idx` out 3: index of the vector currently applied or last sampled.

## Operation
- Vector order by index 0..7 (abc): 000, 001, 011, 010, 110, 111, 101, 100. Each step toggles exactly one input.
- Expected value is `~(a&b&c)`: 1 for every vector except 111 (index 5).
- FSM states and transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → SAMPLE when the settle counter reaches 0.
  - SAMPLE → SETTLE if `vec_idx<7`.
  - SAMPLE → DONE if `vec_idx==7`.
  - DONE → IDLE, or DONE → SETTLE if `start` is high.
- Start edge actions: `err_count`←0, `vec_idx`←0, outputs←000, counter←SETTLE_CYCLES-1, `busy`←1, `pass`←0.
- SETTLE: the counter decrements once per cycle.
- SAMPLE:
  - Compare `dut_w` with the expected value using case inequality. X or Z on `dut_w` counts as a mismatch.
  - On mismatch, `err_count` increments.
  - If `vec_idx<7`: advance `vec_idx`, drive the next vector, reload the counter.
- DONE: `done`=1, `busy`=0, `pass`=(`err_count`==0). `dut_a/b/c` keep the last vector.
- `start` is ignored while `busy`=1.
- Width rules:
  - `err_count` is 4 bits and cannot exceed 8, so it never wraps.
  - The settle counter is 8 bits.
  - `vec_idx` never wraps within a run.

## Timing
- Reset (async assert, sync release): state IDLE; `dut_a/b/c`, `busy`, `done`, `pass`, `err_count` and `vec_idx` all 0.
- Let edge E0 be the edge that samples `start`=1. Vector k is driven after edge E(k·(S+1)) and sampled at edge E((k+1)·(S+1)), where S=SETTLE_CYCLES.
- Per-vector time is S+1 cycles. `done` is high in the cycle after edge E(8·(S+1)).
- A DUT with settle delay ≤ S cycles passes. A delay of S+1 or more fails on the transitions into and out of 111.
- Reset asserted mid-run aborts immediately and returns every output to its reset value. No partial result is retained.

## Configuration
- `NAND3_TESTER_STOP_ON_FAIL_EN` defined: the first mismatch causes SAMPLE → DONE directly. `err_count`=1, `vec_idx` freezes at the failing index, `pass`=0.
- Undefined: all 8 vectors always run and every mismatch is counted.

## Test plan
All scenarios use S=4.
- Ideal combinational NAND on `dut_w`, `start` pulsed → `done` at cycle 41 after E0, `err_count`=0, `pass`=1, `vec_idx`=7, abc=100.
- `dut_w` stuck at 1 → `err_count`=1 (vector 111, index 5), `pass`=0.
- `dut_w` driven by AND3 instead of NAND3 → `err_count`=8, `pass`=0.
- NAND output through a 4-cycle register delay → `pass`=1. Through a 5-cycle delay → `err_count`=2 (indices 5 and 6).
- `rst_n` pulsed low at cycle 20 of a run → all outputs 0 immediately, state IDLE. A new `start` gives a normal 41-cycle run with `pass`=1.
- `NAND3_TESTER_STOP_ON_FAIL_EN` defined, `dut_w` stuck at 1 → `done` at cycle 31, `err_count`=1, `vec_idx`=5, abc=111.
